// File: rtl/stacking_pkg.sv
// stacking_pkg
// Shared definitions for the sparse stacking inner-loop sequencer and the
// blocks around it (compute engine, weight prefetcher).
//   - state_e     : sequencer FSM states
//   - DEF_*       : default layer geometry shared with the compute engine
//   - clog2w()    : port/field width helper that never returns zero
package stacking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CHUNK,
    ST_ISSUE,
    ST_WAIT_END,
    ST_ROW_END
  } state_e;

  localparam int DEF_IFM_Y     = 8;
  localparam int DEF_FIL_X     = 3;
  localparam int DEF_FIL_Y     = 3;
  localparam int DEF_OUT_X     = 6;
  localparam int DEF_CHUNK_NUM = 2;
  localparam int DEF_PSUM      = 32;
  localparam int DEF_RD_CYC    = 16;

  // A one-entry range still needs a 1-bit field.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stacking_fil_range.sv
// stacking_fil_range
// Combinational range of filter rows that an IFM row contributes to.
// Ports:
//   ifm_y_i      : current IFM row
//   fil_start_o  : first valid filter row = max(0, ifm_y-(OUT_Y-1))
//   fil_last_o   : last valid filter row  = min(FIL_Y-1, ifm_y)
module stacking_fil_range
  import stacking_pkg::*;
#(
  parameter int IFM_Y = DEF_IFM_Y,
  parameter int FIL_Y = DEF_FIL_Y,
  parameter int YW    = clog2w(DEF_IFM_Y),
  parameter int FW    = clog2w(DEF_FIL_Y)
) (
  input  logic [YW-1:0] ifm_y_i,
  output logic [FW-1:0] fil_start_o,
  output logic [FW-1:0] fil_last_o
);

  localparam int OUT_Y = IFM_Y - FIL_Y + 1;

  always_comb begin
    fil_start_o = '0;
    fil_last_o  = FW'(FIL_Y - 1);
    // Rows near the bottom of the IFM no longer feed the top filter rows.
    if (int'(ifm_y_i) > OUT_Y - 1) begin
      fil_start_o = FW'(int'(ifm_y_i) - (OUT_Y - 1));
    end
    // Rows near the top of the IFM only reach the first filter rows.
    if (int'(ifm_y_i) < FIL_Y - 1) begin
      fil_last_o = FW'(ifm_y_i);
    end
  end

endmodule

// File: rtl/stacking_loop_seq.sv
// stacking_loop_seq
// Inner-loop sequencer: walks IFM rows, the valid filter rows of each IFM row
// and the output columns, issuing one sub-chunk job per (ifm_y, fil_y, x).
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   loop_z_idx_start_i           : rising edge starts a layer pass
//   sub_chunk_end_i              : compute engine finished the current job
//   fil_loop_y_step_i            : filter sparsemap words per filter row
//   sub_channel_size_i           : IFM elements per output column step
//   ifm_chunk_rdy_i              : per-chunk ready flags
//   rd_fil_sparsemap_first/last_o, rd_fil_nonzero_dat_first_o,
//   rd_ifm_sparsemap_first_o, sparsemap_shift_left_o,
//   rd_ifm_sparsemap_next_o, acc_buf_sel_o : job addresses, held until next job
//   sub_chunk_start_o            : one-cycle job-issue pulse
//   ifm_chunk_rd_sel_o           : chunk buffer being read
//   inner_loop_finish_o          : pulse when an IFM row is consumed
//   out_row_done_o/out_row_idx_o : pulse + index when an output row completes
//   layer_done_o                 : pulse after the last IFM row
//   busy_o                       : high from accepted start to layer_done_o
module stacking_loop_seq
  import stacking_pkg::*;
#(
  parameter int IFM_Y     = DEF_IFM_Y,
  parameter int FIL_X     = DEF_FIL_X,
  parameter int FIL_Y     = DEF_FIL_Y,
  parameter int OUT_X     = DEF_OUT_X,
  parameter int CHUNK_NUM = DEF_CHUNK_NUM,
  parameter int ACC_ROWS  = FIL_Y,
  parameter int PSUM      = DEF_PSUM,
  parameter int RD_CYC    = DEF_RD_CYC
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   loop_z_idx_start_i,
  input  logic                                   sub_chunk_end_i,
  input  logic [31:0]                            fil_loop_y_step_i,
  input  logic [31:0]                            sub_channel_size_i,
  input  logic [CHUNK_NUM-1:0]                   ifm_chunk_rdy_i,
  output logic [clog2w(RD_CYC)-1:0]              rd_fil_sparsemap_first_o,
  output logic [clog2w(RD_CYC)-1:0]              rd_fil_sparsemap_last_o,
  output logic [clog2w(FIL_X*FIL_Y)-1:0]         rd_fil_nonzero_dat_first_o,
  output logic [clog2w(RD_CYC)-1:0]              rd_ifm_sparsemap_first_o,
  output logic [clog2w(PSUM)-1:0]                sparsemap_shift_left_o,
  output logic [clog2w(RD_CYC)-1:0]              rd_ifm_sparsemap_next_o,
  output logic [clog2w(ACC_ROWS*OUT_X)-1:0]      acc_buf_sel_o,
  output logic                                   sub_chunk_start_o,
  output logic [clog2w(CHUNK_NUM)-1:0]           ifm_chunk_rd_sel_o,
  output logic                                   inner_loop_finish_o,
  output logic                                   out_row_done_o,
  output logic [clog2w(IFM_Y-FIL_Y+1)-1:0]       out_row_idx_o,
  output logic                                   layer_done_o,
  output logic                                   busy_o
);

  localparam int RW  = clog2w(RD_CYC);
  localparam int FDW = clog2w(FIL_X * FIL_Y);
  localparam int SW  = clog2w(PSUM);
  localparam int PSH = $clog2(PSUM);
  localparam int AW  = clog2w(ACC_ROWS * OUT_X);
  localparam int CW  = clog2w(CHUNK_NUM);
  localparam int OW  = clog2w(IFM_Y - FIL_Y + 1);
  localparam int YW  = clog2w(IFM_Y);
  localparam int FW  = clog2w(FIL_Y);
  localparam int XW  = clog2w(OUT_X);

  state_e          state_q, state_d;
  logic            start_prev_q, start_prev_d;
  logic            busy_q, busy_d;
  logic [YW-1:0]   ifm_y_q, ifm_y_d;
  logic [FW-1:0]   fil_y_q, fil_y_d;
  logic [FW-1:0]   fil_last_q, fil_last_d;
  logic [XW-1:0]   x_q, x_d;
  logic [31:0]     dat_start_q, dat_start_d;

  logic [RW-1:0]   fil_sm_first_q, fil_sm_first_d;
  logic [RW-1:0]   fil_sm_last_q, fil_sm_last_d;
  logic [FDW-1:0]  fil_dat_first_q, fil_dat_first_d;
  logic [RW-1:0]   ifm_sm_first_q, ifm_sm_first_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [RW-1:0]   ifm_sm_next_q, ifm_sm_next_d;
  logic [AW-1:0]   acc_sel_q, acc_sel_d;
  logic            sub_start_q, sub_start_d;
  logic [CW-1:0]   rd_sel_q, rd_sel_d;
  logic            finish_q, finish_d;
  logic            row_done_q, row_done_d;
  logic [OW-1:0]   row_idx_q, row_idx_d;
  logic            layer_done_q, layer_done_d;

  logic [FW-1:0]   fil_start, fil_last;
  logic            issue;
  int              fil_first;
  int              acc_idx;

  stacking_fil_range #(
    .IFM_Y (IFM_Y),
    .FIL_Y (FIL_Y),
    .YW    (YW),
    .FW    (FW)
  ) u_fil_range (
    .ifm_y_i     (ifm_y_q),
    .fil_start_o (fil_start),
    .fil_last_o  (fil_last)
  );

  // Next-state logic. Pulses and job addresses are registered on the edge
  // that enters ISSUE/ROW_END so they line up with those state cycles.
  always_comb begin
    state_d         = state_q;
    start_prev_d    = loop_z_idx_start_i;
    busy_d          = busy_q;
    ifm_y_d         = ifm_y_q;
    fil_y_d         = fil_y_q;
    fil_last_d      = fil_last_q;
    x_d             = x_q;
    dat_start_d     = dat_start_q;
    fil_sm_first_d  = fil_sm_first_q;
    fil_sm_last_d   = fil_sm_last_q;
    fil_dat_first_d = fil_dat_first_q;
    ifm_sm_first_d  = ifm_sm_first_q;
    shift_d         = shift_q;
    ifm_sm_next_d   = ifm_sm_next_q;
    acc_sel_d       = acc_sel_q;
    sub_start_d     = 1'b0;
    rd_sel_d        = rd_sel_q;
    finish_d        = 1'b0;
    row_done_d      = 1'b0;
    row_idx_d       = row_idx_q;
    layer_done_d    = 1'b0;
    issue           = 1'b0;
    fil_first       = 0;
    acc_idx         = 0;

    case (state_q)
      ST_IDLE: begin
        if (loop_z_idx_start_i && !start_prev_q) begin
          state_d = ST_WAIT_CHUNK;
          ifm_y_d = '0;
          busy_d  = 1'b1;
        end
      end
      ST_WAIT_CHUNK: begin
        if (ifm_chunk_rdy_i[rd_sel_q]) begin
          fil_y_d     = fil_start;
          fil_last_d  = fil_last;
          x_d         = '0;
          dat_start_d = '0;
          state_d     = ST_ISSUE;
          issue       = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (sub_chunk_end_i) begin
          if (int'(x_q) < OUT_X - 1) begin
            x_d         = x_q + 1'b1;
            dat_start_d = dat_start_q + sub_channel_size_i;
            state_d     = ST_ISSUE;
            issue       = 1'b1;
          end else if (fil_y_q < fil_last_q) begin
            fil_y_d     = fil_y_q + 1'b1;
            x_d         = '0;
            dat_start_d = '0;
            state_d     = ST_ISSUE;
            issue       = 1'b1;
          end else begin
            state_d  = ST_ROW_END;
            finish_d = 1'b1;
            rd_sel_d = (int'(rd_sel_q) == CHUNK_NUM - 1) ? '0 : rd_sel_q + 1'b1;
            // The bottom filter row closes an output row once enough IFM
            // rows have been consumed.
            if (int'(ifm_y_q) >= FIL_Y - 1) begin
              row_done_d = 1'b1;
              row_idx_d  = OW'(int'(ifm_y_q) - (FIL_Y - 1));
            end
            if (int'(ifm_y_q) == IFM_Y - 1) begin
              layer_done_d = 1'b1;
              busy_d       = 1'b0;
            end
          end
        end
      end
      ST_ROW_END: begin
        if (int'(ifm_y_q) == IFM_Y - 1) begin
          state_d = ST_IDLE;
        end else begin
          ifm_y_d = ifm_y_q + 1'b1;
          state_d = ST_WAIT_CHUNK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Job addresses follow the loop indices being loaded this edge.
    if (issue) begin
      fil_first       = int'(fil_y_d) * FIL_X;
      fil_sm_first_d  = RW'(fil_first);
      fil_sm_last_d   = RW'(32'(fil_first) + fil_loop_y_step_i - 32'd1);
      fil_dat_first_d = FDW'(fil_y_d);
      ifm_sm_first_d  = RW'(dat_start_d >> PSH);
      shift_d         = dat_start_d[PSH-1:0];
      ifm_sm_next_d   = (int'(x_d) == OUT_X - 1) ? '0 : RW'(sub_channel_size_i - 32'd1);
      // Accumulator rows form a ring indexed by the output row being built.
      acc_idx         = ((int'(ifm_y_q) - int'(fil_y_d)) % ACC_ROWS) * OUT_X + int'(x_d);
      acc_sel_d       = AW'(acc_idx);
      sub_start_d     = 1'b1;
    end
  end

  // All state and outputs; reset clears everything including the chunk
  // pointer, which otherwise survives across layer passes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      start_prev_q    <= 1'b0;
      busy_q          <= 1'b0;
      ifm_y_q         <= '0;
      fil_y_q         <= '0;
      fil_last_q      <= '0;
      x_q             <= '0;
      dat_start_q     <= '0;
      fil_sm_first_q  <= '0;
      fil_sm_last_q   <= '0;
      fil_dat_first_q <= '0;
      ifm_sm_first_q  <= '0;
      shift_q         <= '0;
      ifm_sm_next_q   <= '0;
      acc_sel_q       <= '0;
      sub_start_q     <= 1'b0;
      rd_sel_q        <= '0;
      finish_q        <= 1'b0;
      row_done_q      <= 1'b0;
      row_idx_q       <= '0;
      layer_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      start_prev_q    <= start_prev_d;
      busy_q          <= busy_d;
      ifm_y_q         <= ifm_y_d;
      fil_y_q         <= fil_y_d;
      fil_last_q      <= fil_last_d;
      x_q             <= x_d;
      dat_start_q     <= dat_start_d;
      fil_sm_first_q  <= fil_sm_first_d;
      fil_sm_last_q   <= fil_sm_last_d;
      fil_dat_first_q <= fil_dat_first_d;
      ifm_sm_first_q  <= ifm_sm_first_d;
      shift_q         <= shift_d;
      ifm_sm_next_q   <= ifm_sm_next_d;
      acc_sel_q       <= acc_sel_d;
      sub_start_q     <= sub_start_d;
      rd_sel_q        <= rd_sel_d;
      finish_q        <= finish_d;
      row_done_q      <= row_done_d;
      row_idx_q       <= row_idx_d;
      layer_done_q    <= layer_done_d;
    end
  end

  assign rd_fil_sparsemap_first_o   = fil_sm_first_q;
  assign rd_fil_sparsemap_last_o    = fil_sm_last_q;
  assign rd_fil_nonzero_dat_first_o = fil_dat_first_q;
  assign rd_ifm_sparsemap_first_o   = ifm_sm_first_q;
  assign sparsemap_shift_left_o     = shift_q;
  assign rd_ifm_sparsemap_next_o    = ifm_sm_next_q;
  assign acc_buf_sel_o              = acc_sel_q;
  assign sub_chunk_start_o          = sub_start_q;
  assign ifm_chunk_rd_sel_o         = rd_sel_q;
  assign inner_loop_finish_o        = finish_q;
  assign out_row_done_o             = row_done_q;
  assign out_row_idx_o              = row_idx_q;
  assign layer_done_o               = layer_done_q;
  assign busy_o                     = busy_q;

endmodule

// File: tb/tb_stacking_loop_seq.sv
// tb_stacking_loop_seq
// Scoreboard bench for stacking_loop_seq: stimulus pushes the expected jobs
// and row completions; a monitor pops and compares them as the DUT emits.
module tb_stacking_loop_seq;

  localparam int IFM_Y     = 6;
  localparam int FIL_X     = 3;
  localparam int FIL_Y     = 3;
  localparam int OUT_X     = 3;
  localparam int CHUNK_NUM = 3;
  localparam int ACC_ROWS  = 3;
  localparam int PSUM      = 32;
  localparam int RD_CYC    = 16;
  localparam int STEP      = 3;
  localparam int SCS       = 20;
  localparam int BUDGET    = 2000;

  typedef struct {
    int sel; int ff; int fl; int nz; int ifirst; int shift; int nxt; int acc;
  } job_t;

  typedef struct {
    int row_done; int row_idx; int layer_done; int sel_after;
  } fin_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        eng_end = 1'b0;
  logic        end_inj = 1'b0;
  logic        sub_end;
  logic [31:0] fil_step = 32'(STEP);
  logic [31:0] scs = 32'(SCS);
  logic [2:0]  rdy = 3'b111;

  logic [3:0] fsf, fsl, fdf, isf, isn, acc;
  logic [4:0] shift;
  logic       sstart, fin, rowd, layd, busy;
  logic [1:0] sel, rowi;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int fin_cnt = 0;
  int row_cnt = 0;
  int layer_cnt = 0;

  job_t job_q[$];
  fin_t fin_q[$];

  // Hand-computed filter-row range for each IFM row with OUT_Y = 4.
  int fil_lo[IFM_Y] = '{0, 0, 0, 0, 1, 2};
  int fil_hi[IFM_Y] = '{0, 1, 2, 2, 2, 2};

  assign sub_end = eng_end | end_inj;

  always #5 clk = ~clk;

  stacking_loop_seq #(
    .IFM_Y(IFM_Y), .FIL_X(FIL_X), .FIL_Y(FIL_Y), .OUT_X(OUT_X),
    .CHUNK_NUM(CHUNK_NUM), .ACC_ROWS(ACC_ROWS), .PSUM(PSUM), .RD_CYC(RD_CYC)
  ) dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .loop_z_idx_start_i         (start_i),
    .sub_chunk_end_i            (sub_end),
    .fil_loop_y_step_i          (fil_step),
    .sub_channel_size_i         (scs),
    .ifm_chunk_rdy_i            (rdy),
    .rd_fil_sparsemap_first_o   (fsf),
    .rd_fil_sparsemap_last_o    (fsl),
    .rd_fil_nonzero_dat_first_o (fdf),
    .rd_ifm_sparsemap_first_o   (isf),
    .sparsemap_shift_left_o     (shift),
    .rd_ifm_sparsemap_next_o    (isn),
    .acc_buf_sel_o              (acc),
    .sub_chunk_start_o          (sstart),
    .ifm_chunk_rd_sel_o         (sel),
    .inner_loop_finish_o        (fin),
    .out_row_done_o             (rowd),
    .out_row_idx_o              (rowi),
    .layer_done_o               (layd),
    .busy_o                     (busy)
  );

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Queue the expected responses of one layer pass, then raise the start edge.
  task automatic applyStimulus(input int first_sel);
    job_t j;
    fin_t f;
    for (int y = 0; y < IFM_Y; y++) begin
      for (int fy = fil_lo[y]; fy <= fil_hi[y]; fy++) begin
        for (int x = 0; x < OUT_X; x++) begin
          j.sel    = (first_sel + y) % CHUNK_NUM;
          j.ff     = fy * FIL_X;
          j.fl     = (fy * FIL_X + STEP - 1) % 16;
          j.nz     = fy;
          j.ifirst = ((x * SCS) / 32) % 16;
          j.shift  = (x * SCS) % 32;
          j.nxt    = (x == OUT_X - 1) ? 0 : (SCS - 1) % 16;
          j.acc    = ((y - fy) % ACC_ROWS) * OUT_X + x;
          job_q.push_back(j);
        end
      end
      f.row_done   = (y >= FIL_Y - 1) ? 1 : 0;
      f.row_idx    = y - (FIL_Y - 1);
      f.layer_done = (y == IFM_Y - 1) ? 1 : 0;
      f.sel_after  = (first_sel + y + 1) % CHUNK_NUM;
      fin_q.push_back(f);
    end
    start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic waitLayer(input int target);
    int n = 0;
    while (layer_cnt < target && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
    end
    if (layer_cnt < target) begin
      checkOutput("layer_done_timeout", layer_cnt, target);
    end
  endtask

  task automatic checkLayer(input string name, input int s0, input int r0);
    checkOutput({name, "_jobs"}, start_cnt - s0, 36);
    checkOutput({name, "_rows"}, row_cnt - r0, 4);
    checkOutput({name, "_jobq_left"}, job_q.size(), 0);
    checkOutput({name, "_finq_left"}, fin_q.size(), 0);
    checkOutput({name, "_busy_end"}, int'(busy), 0);
  endtask

  // Compute engine model: finish each job three cycles after its start.
  initial begin
    forever begin
      @(negedge clk);
      if (sstart) begin
        repeat (3) @(posedge clk);
        #1 eng_end = 1'b1;
        @(posedge clk);
        #1 eng_end = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a job or row event.
  initial begin
    job_t j;
    fin_t f;
    forever begin
      @(negedge clk);
      if (sstart) begin
        start_cnt++;
        if (job_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_start got 1 expected 0");
        end else begin
          j = job_q.pop_front();
          checkOutput("job_rd_sel", int'(sel), j.sel);
          checkOutput("job_fil_sm_first", int'(fsf), j.ff);
          checkOutput("job_fil_sm_last", int'(fsl), j.fl);
          checkOutput("job_fil_dat_first", int'(fdf), j.nz);
          checkOutput("job_ifm_sm_first", int'(isf), j.ifirst);
          checkOutput("job_shift", int'(shift), j.shift);
          checkOutput("job_ifm_sm_next", int'(isn), j.nxt);
          checkOutput("job_acc_sel", int'(acc), j.acc);
        end
      end
      if (fin) begin
        fin_cnt++;
        if (rowd) row_cnt++;
        if (layd) layer_cnt++;
        if (fin_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_finish got 1 expected 0");
        end else begin
          f = fin_q.pop_front();
          checkOutput("fin_row_done", int'(rowd), f.row_done);
          if (f.row_done != 0) checkOutput("fin_row_idx", int'(rowi), f.row_idx);
          checkOutput("fin_layer_done", int'(layd), f.layer_done);
          checkOutput("fin_rd_sel", int'(sel), f.sel_after);
        end
      end else if (rowd || layd) begin
        checks++; errors++;
        $display("[TB] FAIL orphan_row_event got %0d expected 0", {rowd, layd});
      end
    end
  end

  initial begin
    int s0, r0, n;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_rd_sel", int'(sel), 0);
    checkOutput("reset_pulses", int'({sstart, fin, rowd, layd}), 0);
    checkOutput("reset_addr", int'({fsf, fsl, fdf, isf, shift, isn, acc, rowi}), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Layer 1: all chunks ready.
    $display("[TB] layer 1: free running");
    s0 = start_cnt; r0 = row_cnt;
    applyStimulus(0);
    checkOutput("busy_after_start", int'(busy), 1);
    waitLayer(1);
    checkLayer("layer1", s0, r0);

    // Layer 2: chunk 1 not ready, so the second IFM row must stall.
    $display("[TB] layer 2: chunk 1 stalled");
    rdy = 3'b101;
    s0 = start_cnt; r0 = row_cnt;
    applyStimulus(0);
    n = 0;
    while (fin_cnt < 7 && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("stall_first_row_done", fin_cnt, 7);
    n = start_cnt;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("stall_no_starts", start_cnt - n, 0);
    checkOutput("stall_rd_sel", int'(sel), 1);
    checkOutput("stall_busy", int'(busy), 1);
    rdy = 3'b111;
    waitLayer(2);
    checkLayer("layer2", s0, r0);

    // Layer 3: a second start edge while busy must be ignored.
    $display("[TB] layer 3: start edge while busy");
    s0 = start_cnt; r0 = row_cnt;
    applyStimulus(0);
    repeat (20) @(posedge clk);
    #1 start_i = 1'b1;
    waitLayer(3);
    checkLayer("layer3", s0, r0);
    n = start_cnt;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("held_start_no_restart", start_cnt - n, 0);
    start_i = 1'b0;

    // End pulse in IDLE must not do anything.
    n = start_cnt;
    end_inj = 1'b1;
    repeat (2) @(posedge clk);
    #1 end_inj = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle_end_busy", int'(busy), 0);
    checkOutput("idle_end_no_start", start_cnt - n, 0);
    checkOutput("idle_end_no_layer", layer_cnt, 3);

    // Reset while waiting for a job end in the second IFM row.
    $display("[TB] reset mid-layer");
    s0 = start_cnt;
    applyStimulus(0);
    n = 0;
    while (start_cnt < s0 + 5 && n < BUDGET) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("pre_reset_jobs", start_cnt - s0, 5);
    checkOutput("pre_reset_rd_sel", int'(sel), 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_rd_sel", int'(sel), 0);
    checkOutput("midreset_pulses", int'({sstart, fin, rowd, layd}), 0);
    checkOutput("midreset_addr", int'({fsf, fsl, fdf, isf, shift, isn, acc, rowi}), 0);
    job_q.delete();
    fin_q.delete();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Restart after reset: begins at IFM row 0 reading chunk 0.
    $display("[TB] layer 4: restart after reset");
    s0 = start_cnt; r0 = row_cnt;
    applyStimulus(0);
    waitLayer(4);
    checkLayer("layer4", s0, r0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
